// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the port-B arbiter slice.
package mem_arb_pkg;

  localparam int PORTB_ADDR_W = 18;
  localparam int PORTB_DATA_W = 24;

  // Who holds port B. The last-served requester is stored with the same type.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } owner_t;

  // Read-return tag values.
  localparam logic TAG_R0 = 1'b0;
  localparam logic TAG_R1 = 1'b1;

  // One read-pipe slot: an outstanding read and the requester it belongs to.
  typedef struct packed {
    logic valid;
    logic tag;
  } rd_entry_t;

endpackage

// File: rtl/read_tag_pipe.sv
// Fixed-depth shift register that carries read tags alongside the memory read
// latency, so each returning word can be routed to the requester that asked.
module read_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  rd_entry_t issue,
  output rd_entry_t retire
);

  rd_entry_t stage [DEPTH];

  // Shift tags one stage per clock; reset drops every in-flight read.
  // NOTE: these slots are cleared on reset (unlike a data RAM) because a stale
  // valid bit would produce a spurious rvalid after reset.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the value from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= issue;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign retire = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_b_arbiter.sv
// Shares memory port B between display scanout (read-only, requester 0) and
// the debug/loader (read/write, requester 1) with bounded-burst round robin,
// single-cycle accepts and tagged read returns.
module mem_port_b_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = PORTB_ADDR_W,
  parameter int DATA_W       = PORTB_DATA_W,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  localparam int                 BURST_W   = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  owner_t             owner;
  owner_t             last;
  owner_t             sel;
  logic [BURST_W-1:0] burst_cnt;
  logic               own_req;
  logic               other_req;
  logic               keep;
  logic               conflict;
  rd_entry_t          issue;
  rd_entry_t          retire;

  // Pick this cycle's winner: stay with the owner until its burst is spent
  // under contention, otherwise serve the requester that went least recently.
  // NOTE: every variable gets a default before the branches, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    sel       = OWN_NONE;
    case (owner)
      OWN_R0: begin
        own_req   = req0;
        other_req = req1;
      end
      OWN_R1: begin
        own_req   = req1;
        other_req = req0;
      end
      default: ;
    endcase
    keep = (owner != OWN_NONE) && own_req &&
           ((burst_cnt < BURST_MAX) || !other_req);
    if (keep) begin
      sel = owner;
    end else if (req0 && req1) begin
      sel = (last == OWN_R0) ? OWN_R1 : OWN_R0;
    end else if (req0) begin
      sel = OWN_R0;
    end else if (req1) begin
      sel = OWN_R1;
    end
  end

  // Grants are same-cycle accepts, held off entirely while reset is asserted.
  assign gnt0 = rst && (sel == OWN_R0);
  assign gnt1 = rst && (sel == OWN_R1);

  // Drive the port-B pins from whichever requester was accepted.
  always_comb begin
    mem_addr = '0;
    if (gnt0) begin
      mem_addr = addr0;
    end else if (gnt1) begin
      mem_addr = addr1;
    end
  end

  assign mem_we    = gnt1 & we1;
  assign mem_wdata = gnt1 ? wdata1 : '0;

  // Only accepted reads enter the return pipe; writes never come back.
  assign issue.valid = (gnt0 | gnt1) & ~mem_we;
  assign issue.tag   = gnt1 ? TAG_R1 : TAG_R0;

  assign conflict = (req0 & ~gnt0) | (req1 & ~gnt1);

  // Arbitration state: current owner, last-served requester, burst length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWN_NONE;
      last      <= OWN_R1;
      burst_cnt <= '0;
    end else begin
      owner <= sel;
      if (sel != OWN_NONE) begin
        last <= sel;
      end
      if (sel != OWN_NONE && sel == owner) begin
        burst_cnt <= (burst_cnt < BURST_MAX) ? burst_cnt + BURST_ONE : BURST_MAX;
      end else if (sel != OWN_NONE) begin
        burst_cnt <= BURST_ONE;
      end else begin
        burst_cnt <= '0;
      end
    end
  end

  // Saturating count of cycles in which some request had to wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else if (conflict && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  read_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_read_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .issue  (issue),
    .retire (retire)
  );

  // Read data is broadcast; the tag decides which requester sees it as valid.
  assign rvalid0 = rst && retire.valid && (retire.tag == TAG_R0);
  assign rvalid1 = rst && retire.valid && (retire.tag == TAG_R1);
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

endmodule

// File: tb/tb_mem_port_b_arbiter.sv
// Directed bench for mem_port_b_arbiter. Two instances: dut_a with the default
// burst of 8, dut_b with a burst of 1. Each has a synchronous memory model.
// Expected read returns go into per-requester queues; monitors compare them.
module tb_mem_port_b_arbiter;

  typedef struct {
    logic [23:0] data;
    int          due;
  } sb_entry_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  bit   mon_en_a = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut_a signals
  logic        req0_a = 0, req1_a = 0, we1_a = 0;
  logic [17:0] addr0_a = 0, addr1_a = 0;
  logic [23:0] wdata1_a = 0;
  logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, mem_we_a;
  logic [23:0] rdata0_a, rdata1_a, mem_wdata_a, mem_rdata_a;
  logic [17:0] mem_addr_a;
  logic [15:0] conflict_cnt_a;

  // dut_b signals
  logic        req0_b = 0, req1_b = 0, we1_b = 0;
  logic [17:0] addr0_b = 0, addr1_b = 0;
  logic [23:0] wdata1_b = 0;
  logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, mem_we_b;
  logic [23:0] rdata0_b, rdata1_b, mem_wdata_b, mem_rdata_b;
  logic [17:0] mem_addr_b;
  logic [15:0] conflict_cnt_b;

  logic [23:0] mem_a [0:1023];
  logic [23:0] mem_b [0:1023];

  sb_entry_t q_a0[$], q_a1[$], q_b0[$], q_b1[$];

  mem_port_b_arbiter #(.READ_LATENCY(1), .MAX_BURST(8)) dut_a (
    .clk(clk), .rst(rst),
    .req0(req0_a), .addr0(addr0_a), .gnt0(gnt0_a), .rvalid0(rvalid0_a), .rdata0(rdata0_a),
    .req1(req1_a), .we1(we1_a), .addr1(addr1_a), .wdata1(wdata1_a),
    .gnt1(gnt1_a), .rvalid1(rvalid1_a), .rdata1(rdata1_a),
    .mem_addr(mem_addr_a), .mem_we(mem_we_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .conflict_cnt(conflict_cnt_a)
  );

  mem_port_b_arbiter #(.READ_LATENCY(1), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0_b), .addr0(addr0_b), .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
    .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b),
    .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
    .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .conflict_cnt(conflict_cnt_b)
  );

  // One-clock synchronous memories, read-before-write.
  always @(posedge clk) begin
    if (mem_we_a) mem_a[mem_addr_a[9:0]] <= mem_wdata_a;
    mem_rdata_a <= mem_a[mem_addr_a[9:0]];
    if (mem_we_b) mem_b[mem_addr_b[9:0]] <= mem_wdata_b;
    mem_rdata_b <= mem_b[mem_addr_b[9:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Monitors: every rvalid must match the oldest expected return, on time.
  always @(negedge clk) begin
    sb_entry_t e;
    if (mon_en_a && rst && rvalid0_a) begin
      if (q_a0.size() == 0) check("a0 unexpected rvalid0", 1, 0);
      else begin
        e = q_a0.pop_front();
        check("a0 rdata0", rdata0_a, e.data);
        check("a0 rvalid0 cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    sb_entry_t e;
    if (mon_en_a && rst && rvalid1_a) begin
      if (q_a1.size() == 0) check("a1 unexpected rvalid1", 1, 0);
      else begin
        e = q_a1.pop_front();
        check("a1 rdata1", rdata1_a, e.data);
        check("a1 rvalid1 cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    sb_entry_t e;
    if (rst && rvalid0_b) begin
      if (q_b0.size() == 0) check("b0 unexpected rvalid0", 1, 0);
      else begin
        e = q_b0.pop_front();
        check("b0 rdata0", rdata0_b, e.data);
        check("b0 rvalid0 cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    sb_entry_t e;
    if (rst && rvalid1_b) begin
      if (q_b1.size() == 0) check("b1 unexpected rvalid1", 1, 0);
      else begin
        e = q_b1.pop_front();
        check("b1 rdata1", rdata1_b, e.data);
        check("b1 rvalid1 cycle", cyc, e.due);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 24'h0;
      mem_b[i] = 24'h0;
    end
    mem_a[10'h040] = 24'hC0FFEE;
    mem_a[10'h100] = 24'hA1B2C3;
    mem_a[10'h200] = 24'h5A5A5A;
    mem_b[10'h100] = 24'h0F1E2D;
    mem_b[10'h200] = 24'h3C4B5A;

    // Reset with display request held: nothing may be granted or driven.
    req0_a = 1; addr0_a = 18'h00040;
    repeat (2) tick();
    settle();
    check("rst gnt0", gnt0_a, 0);
    check("rst rvalid0", rvalid0_a, 0);
    check("rst mem_we", mem_we_a, 0);
    check("rst mem_addr", mem_addr_a, 0);
    check("rst conflict_cnt", conflict_cnt_a, 0);
    tick();
    rst = 1;
    settle();
    check("first gnt0", gnt0_a, 1);
    check("first mem_addr", mem_addr_a, 18'h00040);
    q_a0.push_back('{data: 24'hC0FFEE, due: cyc + 1});
    tick();
    req0_a = 0;
    settle();
    check("idle gnt0", gnt0_a, 0);

    // Loader alone: write then read back the same word.
    tick();
    req1_a = 1; we1_a = 1; addr1_a = 18'h00010; wdata1_a = 24'h123456;
    settle();
    check("wr gnt1", gnt1_a, 1);
    check("wr mem_we", mem_we_a, 1);
    check("wr mem_addr", mem_addr_a, 18'h00010);
    check("wr mem_wdata", mem_wdata_a, 24'h123456);
    tick();
    we1_a = 0; wdata1_a = 24'h0;
    settle();
    check("rd gnt1", gnt1_a, 1);
    check("rd mem_we", mem_we_a, 0);
    check("rd mem_addr", mem_addr_a, 18'h00010);
    q_a1.push_back('{data: 24'h123456, due: cyc + 1});
    tick();
    req1_a = 0;
    settle();
    check("after rd mem_we", mem_we_a, 0);
    tick();

    // Contention from reset with a burst of 8.
    rst = 0;
    repeat (2) tick();
    rst = 1;
    req0_a = 1; addr0_a = 18'h00100;
    req1_a = 1; we1_a = 0; addr1_a = 18'h00200;
    for (int k = 1; k <= 8; k++) begin
      settle();
      check($sformatf("burst c%0d gnt0", k), gnt0_a, 1);
      check($sformatf("burst c%0d gnt1", k), gnt1_a, 0);
      q_a0.push_back('{data: 24'hA1B2C3, due: cyc + 1});
      tick();
    end
    settle();
    check("burst c9 gnt1", gnt1_a, 1);
    check("burst c9 gnt0", gnt0_a, 0);
    check("burst c9 mem_addr", mem_addr_a, 18'h00200);
    check("burst conflict after c8", conflict_cnt_a, 8);
    q_a1.push_back('{data: 24'h5A5A5A, due: cyc + 1});
    tick();
    req1_a = 0;
    settle();
    check("burst c10 gnt0", gnt0_a, 1);
    check("burst conflict after c9", conflict_cnt_a, 9);
    q_a0.push_back('{data: 24'hA1B2C3, due: cyc + 1});
    tick();
    req0_a = 0;
    settle();
    check("burst conflict after c10", conflict_cnt_a, 9);
    tick();

    // Read accepted, then reset pulsed: the read must never return.
    req0_a = 1; addr0_a = 18'h00100;
    settle();
    check("drop gnt0", gnt0_a, 1);
    tick();
    rst = 0; req0_a = 0;
    settle();
    check("drop rvalid0", rvalid0_a, 0);
    check("drop gnt0 in rst", gnt0_a, 0);
    check("drop conflict_cnt", conflict_cnt_a, 0);
    tick();
    rst = 1;
    req0_a = 1; req1_a = 1; we1_a = 0; addr1_a = 18'h00200;
    settle();
    check("post-rst tie gnt0", gnt0_a, 1);
    check("post-rst tie gnt1", gnt1_a, 0);
    q_a0.push_back('{data: 24'hA1B2C3, due: cyc + 1});
    tick();
    req0_a = 0; req1_a = 0;
    settle();
    tick();

    // Burst of 1: strict alternation, interleaved returns.
    req0_b = 1; addr0_b = 18'h00100;
    req1_b = 1; we1_b = 0; addr1_b = 18'h00200;
    for (int k = 0; k < 6; k++) begin
      settle();
      if (k % 2 == 0) begin
        check($sformatf("alt %0d gnt0", k), gnt0_b, 1);
        check($sformatf("alt %0d gnt1", k), gnt1_b, 0);
        check($sformatf("alt %0d mem_addr", k), mem_addr_b, 18'h00100);
        q_b0.push_back('{data: 24'h0F1E2D, due: cyc + 1});
      end else begin
        check($sformatf("alt %0d gnt1", k), gnt1_b, 1);
        check($sformatf("alt %0d gnt0", k), gnt0_b, 0);
        check($sformatf("alt %0d mem_addr", k), mem_addr_b, 18'h00200);
        q_b1.push_back('{data: 24'h3C4B5A, due: cyc + 1});
      end
      tick();
    end
    req0_b = 0; req1_b = 0;
    settle();
    tick();

    // Long contention: counter must saturate and stay there.
    mon_en_a = 1'b0;
    req0_a = 1; addr0_a = 18'h00100;
    req1_a = 1; we1_a = 0; addr1_a = 18'h00200;
    repeat (70000) tick();
    settle();
    check("conflict saturated", conflict_cnt_a, 16'hFFFF);
    tick();
    settle();
    check("conflict held at max", conflict_cnt_a, 16'hFFFF);
    req0_a = 0; req1_a = 0;
    repeat (3) tick();
    mon_en_a = 1'b1;

    check("q_a0 drained", q_a0.size(), 0);
    check("q_a1 drained", q_a1.size(), 0);
    check("q_b0 drained", q_b0.size(), 0);
    check("q_b1 drained", q_b1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_b_arbiter.md
Name: mem_port_b_arbiter

Overview:
- Shares data memory port B (24-bit words, 18-bit address) between two requesters: requester 0 is display scanout (read-only), requester 1 is the debug/loader (read/write).
- Sits between those requesters and the memory_stage port-B pins.
- Bounded-burst round-robin arbitration with single-cycle accept handshakes.
- Returns read data to the originating requester after the fixed memory read latency.

Parameters:
- ADDR_W, 18, port-B address width.
- DATA_W, 24, data word width.
- READ_LATENCY, 1, clocks from accepted read to mem_rdata valid (≥1).
- MAX_BURST, 8, consecutive accepts one owner may take while the other is requesting (≥1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  display read request.
- addr0  in  ADDR_W  display read address.
- gnt0  out  1  display request accepted this cycle.
- rvalid0  out  1  display read data valid.
- rdata0  out  DATA_W  display read data.
- req1  in  1  loader request.
- we1  in  1  loader write (1) / read (0).
- addr1  in  ADDR_W  loader address.
- wdata1  in  DATA_W  loader write data.
- gnt1  out  1  loader request accepted this cycle.
- rvalid1  out  1  loader read data valid.
- rdata1  out  DATA_W  loader read data.
- mem_addr  out  ADDR_W  to memory address_b.
- mem_we  out  1  to memory port-B write enable.
- mem_wdata  out  DATA_W  to memory port-B write data.
- mem_rdata  in  DATA_W  from memory read_data_b.
- conflict_cnt  out  16  saturating count of cycles where a request was not granted.

Behaviour:
- Registered state: owner ∈ {NONE, R0, R1}, last (R0/R1), burst_cnt (0..MAX_BURST, saturating), read pipe of READ_LATENCY entries {valid, tag}, conflict_cnt.
- Reset (rst low, immediate): owner=NONE, last=R1 (display wins first tie), burst_cnt=0, pipe cleared, conflict_cnt=0. gnt0/gnt1/rvalid0/rvalid1/mem_we forced 0 and mem_addr/mem_wdata forced 0 while rst low. In-flight reads are dropped and never return.
- Combinational select per cycle:
  - Keep owner if req[owner]=1 and (burst_cnt<MAX_BURST or req[other]=0).
  - Otherwise, if both requesting, select the one ≠ last.
  - Otherwise, if exactly one is requesting, select it.
  - Otherwise select NONE.
- gntN = (sel==N). Handshake: request and address are held by the requester until gnt; gnt is a same-cycle accept, zero wait when free.
- Memory drive:
  - mem_addr = addr of sel (0 if NONE).
  - mem_we = gnt1 & we1.
  - mem_wdata = wdata1 when gnt1, else 0.
- Clock update:
  - owner<=sel.
  - If sel≠NONE, last<=sel.
  - burst_cnt <= (sel==owner && sel≠NONE) ? min(burst_cnt+1, MAX_BURST) : (sel≠NONE ? 1 : 0).
- Read return:
  - Pipe stage0 <= {gnt & ~mem_we, sel}, shifted each clock.
  - At pipe output: rvalidN = valid && tag==N.
  - rdata0 = rdata1 = mem_rdata (qualified only by rvalidN).
  - Read latency = READ_LATENCY clocks after gnt.
  - Writes produce no rvalid.
- Back-to-back: a new accept is allowed every cycle, including owner switch with zero bubble; reads from both requesters may interleave in the pipe and each returns to its own tag.
- conflict_cnt increments when (req0 & ~gnt0) | (req1 & ~gnt1) and saturates at 16'hFFFF.
- MAX_BURST=1 gives pure alternation under contention.

Decomposition:
- Shared package mem_arb_pkg: owner_t enum {OWN_NONE, OWN_R0, OWN_R1}, read-pipe entry struct {valid, tag}, port-B width constants (ADDR_W=18, DATA_W=24).
- One sub-module: read_tag_pipe (READ_LATENCY-deep shift register of entries with async active-low clear).

Test Plan:
- Reset with req0=1 held → gnt0=0, rvalid0=0, mem_we=0. First clk after rst release → gnt0=1, mem_addr=addr0, rvalid0=1 one clock later with rdata0 = memory word.
- Both req from reset, MAX_BURST=8 → gnt0 for cycles 1–8, gnt1 cycle 9, back to gnt0 at cycle 10 if loader drops; conflict_cnt=8 after cycle 8.
- Loader alone writes 0x123456 at 0x00010 then reads it → mem_we=1 only on write cycle; rvalid1=1 with rdata1=0x123456; rvalid0 stays 0.
- Alternating reads R0@0x00100, R1@0x00200 under MAX_BURST=1 → gnt toggles each cycle; returns arrive in order, each on the matching rvalidN with the correct word.
- Read accepted, then rst pulsed low on the next cycle → no rvalid for that read; state back to reset values.
- Hold both req for 70000 cycles → conflict_cnt saturates at 0xFFFF.
